// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - load/store initiator for the single-port data memory
//
// Accepts one load/store request at a time, turns the byte address into a word
// index, drives the memory strobes with one setup cycle and WAIT_CYCLES extra
// hold cycles, then returns the result over a valid/ready response channel.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr, req_wdata store flag, byte address, store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        load data (0 for stores/errors), error flag
//   stall                       high while a transaction is in flight
//   mem_address, mem_write_data word index and store data to the memory
//   mem_read, mem_write         memory strobes (never both high)
//   mem_read_data               combinational read data from the memory
module mem_access_master #(
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [DATA_W-1:0] WORDS     = DATA_W'(MEM_WORDS);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] req_index;
  logic              req_bad;

  assign req_index = {2'b00, req_addr[DATA_W-1:2]};
  assign req_bad   = (req_addr[1:0] != 2'b00) || (req_index >= WORDS);

  // All handshake and strobe outputs decode from registered state only.
  assign req_ready      = (state == IDLE);
  assign stall          = (state != IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = (state == ACCESS) && !we_q;
  assign mem_write      = (state == ACCESS) && we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (req_valid) state_nxt = req_bad ? RESP : SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (cnt == 4'd0) state_nxt = RESP;
      RESP:   if (resp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q <= req_we;
            if (req_bad) begin
              // Rejected requests never touch the memory-facing registers.
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              addr_q  <= req_index;
              wdata_q <= req_wdata;
            end
          end
        end
        SETUP: cnt <= WAIT_INIT;
        ACCESS: begin
          if (cnt == 4'd0) begin
            rdata_q <= we_q ? '0 : mem_read_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (resp_ready) err_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// tb/tb_mem_access_master.sv - directed self-checking bench for mem_access_master
module tb_mem_access_master;

  localparam int W  = 32;
  localparam int MW = 1024;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [W-1:0]  req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_rdata;
  logic          resp_err;
  logic          stall;
  logic [W-1:0]  mem_address;
  logic [W-1:0]  mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic [W-1:0]  mem_read_data;

  logic [W-1:0]  mem [0:MW-1];

  int errors = 0;
  int checks = 0;

  mem_access_master #(.DATA_W(W), .MEM_WORDS(MW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},   32'(req_ready),  32'd1);
    check({tag, "_stall"}, 32'(stall),      32'd0);
    check({tag, "_vld"},   32'(resp_valid), 32'd0);
    check({tag, "_err"},   32'(resp_err),   32'd0);
    check({tag, "_strb"},  32'({mem_read, mem_write}), 32'd0);
  endtask

  // Issue one request, follow it to the response, optionally hold off the
  // response for 'hold' cycles, then hand it off and confirm return to IDLE.
  task automatic do_req(input string tag, input logic we, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic [W-1:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_strobe,
                        input logic [W-1:0] exp_idx, input int hold);
    int lat, rd, wr, bad;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1; rd = 0; wr = 0; bad = 0;
    while (!resp_valid && lat < 50) begin
      if (mem_read) rd++;
      if (mem_write) wr++;
      if (mem_read && mem_write) bad++;
      if ((mem_read || mem_write) && mem_address !== exp_idx) bad++;
      if (mem_write && mem_write_data !== wdata) bad++;
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd_cycles"}, 32'(rd), we ? 32'd0 : 32'(exp_strobe));
    check({tag, "_wr_cycles"}, 32'(wr), we ? 32'(exp_strobe) : 32'd0);
    check({tag, "_strobe_bad"}, 32'(bad), 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_bp_vld"}, 32'(resp_valid), 32'd1);
      check({tag, "_bp_rdata"}, resp_rdata, exp_rdata);
      check({tag, "_bp_addr"}, mem_address, exp_idx);
      check({tag, "_bp_rdy_stall"}, 32'({req_ready, stall}), 32'b01);
      check({tag, "_bp_strb"}, 32'({mem_read, mem_write}), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_idle_outputs({tag, "_done"});
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 32'(i) ^ 32'hA5A50000;
    mem[5]    = 32'hDEADBEEF;
    mem[MW-1] = 32'hCAFEF00D;

    rst = 1'b1;
    step();
    step();
    check_idle_outputs("reset");
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_addr", mem_address, 32'd0);
    check("reset_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    step();

    do_req("load5", 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 4, 2, 32'd5, 0);
    do_req("store8", 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 4, 2, 32'd8, 0);
    do_req("load8", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 4, 2, 32'd8, 0);
    do_req("load_last", 1'b0, 32'((MW-1)*4), 32'h0, 32'hCAFEF00D, 1'b0, 4, 2, 32'(MW-1), 0);
    do_req("misalign", 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 32'(MW-1), 0);
    do_req("oor", 1'b1, 32'(MW*4), 32'h55, 32'h0, 1'b1, 1, 0, 32'(MW-1), 0);
    do_req("backpr", 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 4, 2, 32'd5, 5);

    // Reset while a store is in its first ACCESS cycle.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
    step();
    req_valid = 1'b0;
    step();
    check("rst_mid_in_access", 32'(mem_write), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid_addr", mem_address, 32'd0);
    check("rst_mid_wdata", mem_write_data, 32'd0);
    check("rst_mid_rdata", resp_rdata, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (resp_valid || stall) seen++;
        step();
      end
      check("rst_mid_no_resp", 32'(seen), 32'd0);
    end
    do_req("post_rst_load", 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 4, 2, 32'd5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
# mem_access_master

Initiator-side controller for the single-port data memory. Accepts load/store requests from the pipeline's memory stage over a valid/ready handshake and converts byte addresses to word indices. Drives the memory's read/write strobes with setup and hold guarantees, captures read data and returns a response over a second valid/ready handshake. Holds the pipeline stalled for the duration of each access.

## Interface
Parameters:
- DATA_W, 32, data and address width (matches instruction/data word length)
- MEM_WORDS, 1024, number of words in the target memory; word indices at or above this value are out of range
- WAIT_CYCLES, 1, extra cycles the strobe is held beyond the first access cycle (0..15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  pipeline has a request
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  DATA_W  byte address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range
- stall  out  1  high whenever state is not IDLE
- mem_address  out  DATA_W  word index to memory
- mem_write_data  out  DATA_W  store data to memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_read_data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, latch we, wdata, and index = req_addr >> 2.
  - If req_addr[1:0] != 0 or index >= MEM_WORDS: set err = 1 and rdata = 0, then go to RESP. No strobe is ever raised on this path.
  - Otherwise, load mem_address and mem_write_data and go to SETUP.
- SETUP: address and data are driven with both strobes low, for one cycle. Next state is ACCESS, with wait counter = WAIT_CYCLES.
- ACCESS: mem_read = ~we and mem_write = we. The strobe is held while the counter decrements.
  - When the counter is 0: for loads, capture mem_read_data into rdata; for stores, set rdata = 0. Go to RESP.
- RESP: strobes are low, and mem_address/mem_write_data are unchanged from ACCESS (hold).
  - resp_valid = 1 with stable rdata and err until resp_ready is sampled high. Then go to IDLE and clear err.
- mem_read and mem_write are never both high.
- mem_address and mem_write_data change only on the IDLE→SETUP edge, so the combinational memory sees no address or data change while a strobe is high.
- Requests arriving while not in IDLE are not accepted; the requester must hold them (req_ready = 0).

## Timing
- Reset (rst high at a rising edge) forces:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - stall = 0
  - mem_read = 0, mem_write = 0
  - mem_address = 0, mem_write_data = 0
  - wait counter = 0
- Reset mid-operation (SETUP, ACCESS or RESP): the transaction is dropped with no response, and strobes are low from the next cycle.
- Request accepted at the end of cycle n gives:
  - SETUP in cycle n+1
  - ACCESS in cycles n+2 .. n+2+WAIT_CYCLES
  - resp_valid first high in cycle n+3+WAIT_CYCLES
- Error path: resp_valid is first high in cycle n+1.
- Back-to-back: the response is handed off at the end of cycle m, req_ready is high in cycle m+1, so there is one idle cycle minimum between accesses.
- req_ready and stall are decoded from registered state only. No input-to-output combinational path exists except mem_read_data to the internal capture register.

## Test plan
- Load, WAIT_CYCLES=1:
  - Stimulus: memory word 5 preloaded with 0xDEADBEEF; request req_addr=0x14, we=0.
  - Required: mem_read is high for exactly 2 cycles with mem_address=5; resp_valid rises 4 cycles after acceptance with rdata=0xDEADBEEF, err=0.
- Store then load:
  - Stimulus: store 0x12345678 to 0x20, then load 0x20.
  - Required: mem_write is high 2 cycles with mem_address=8 and mem_write_data stable; the store response has rdata=0; the load returns 0x12345678.
- Misaligned and out-of-range errors:
  - Stimulus: req_addr=0x22 (misaligned), then req_addr=MEM_WORDS*4 (out of range).
  - Required: each gives resp_err=1 one cycle after acceptance, rdata=0, and mem_read/mem_write never assert.
- Response backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles during a load.
  - Required: resp_valid, rdata and mem_address stay stable; req_ready=0 and stall=1 throughout; strobes stay low.
- Reset during ACCESS:
  - Stimulus: assert rst in the first ACCESS cycle of a store.
  - Required: all outputs take their reset values at the next edge, resp_valid is never raised, and a subsequent load completes normally.
